// File: rtl/sys_id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_id_pkg
// Description : Shared constants for the system-ID ROM loader and the
//               system-ID register block.
//               - FSM state encoding of the loader.
//               - Additive checksum target.
//               - Magic and version words carried in the ID image.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_id_pkg;

  // Loader FSM state encoding
  localparam int          STATE_W  = 3;
  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_LOAD  = 3'd1;
  localparam logic [2:0]  ST_DRAIN = 3'd2;
  localparam logic [2:0]  ST_DONE  = 3'd3;
  localparam logic [2:0]  ST_ERROR = 3'd4;

  // The sum of all image words plus the checksum word must wrap to this value
  localparam logic [31:0] CHECKSUM_OK = 32'h0000_0000;

  // Identification words expected at the head of the image ("SYID", v1.0)
  localparam logic [31:0] SYS_ID_MAGIC   = 32'h5359_4944;
  localparam logic [31:0] SYS_ID_VERSION = 32'h0001_0000;

endpackage
`default_nettype wire

// File: rtl/sys_id_rom_ram.sv
`default_nettype none
// ============================================================================
// Module      : sys_id_rom_ram
// Description : Simple dual-port RAM that holds the ID image.
//               - One synchronous write port.
//               - One registered read port with 1-cycle latency.
//               - No reset on the array or the read register, so that it
//                 maps onto block or distributed RAM.
// Ports       : clk            - clock
//               we/waddr/wdata - write port
//               raddr/rdata    - read port, rdata valid one cycle after raddr
// Revision    : 1.0 - initial release
// ============================================================================
module sys_id_rom_ram #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sys_id_rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : sys_id_rom_loader
// Description : Boot-time loader for the system-ID ROM image.
//               - Accepts the image on a valid/ready word stream.
//               - The final word (s_last) is an additive checksum.
//               - Serves registered reads to the system-ID block once a
//                 load has completed with a good checksum; returns zero
//                 otherwise.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               load_start        - pulse that starts or restarts a load
//               s_valid/s_ready/s_data/s_last - image word stream
//               rom_addr/rom_data - read port, 1-cycle latency
//               load_busy/load_done/load_error - status
//               word_count        - image words stored by the last load
// Revision    : 1.0 - initial release
// ============================================================================
module sys_id_rom_loader
  import sys_id_pkg::*;
#(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [ROM_WIDTH-1:0]     s_data,
  input  logic                     s_last,
  input  logic [ROM_ADDR_BITS-1:0] rom_addr,
  output logic [ROM_WIDTH-1:0]     rom_data,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_error,
  output logic [ROM_ADDR_BITS:0]   word_count
);

  localparam logic [ROM_ADDR_BITS:0] c_depth = {1'b1, {ROM_ADDR_BITS{1'b0}}};

  logic [STATE_W-1:0]     r_state;
  logic [STATE_W-1:0]     w_state_nxt;
  logic [ROM_ADDR_BITS:0] r_cnt;
  logic [ROM_WIDTH-1:0]   r_acc;
  logic [ROM_ADDR_BITS:0] r_word_count;
  logic                   r_rd_en;
  logic [ROM_WIDTH-1:0]   w_ram_q;
  logic                   w_accept;
  logic                   w_full;
  logic                   w_sum_ok;
  logic [ROM_WIDTH-1:0]   w_sum;
  logic                   w_we;

  assign w_accept = s_valid && s_ready;
  assign w_sum    = r_acc + s_data;
  assign w_sum_ok = (w_sum == ROM_WIDTH'(CHECKSUM_OK));
  // Counter has one extra bit so that "memory full" is distinguishable
  assign w_full   = (r_cnt == c_depth);
  // A load_start in the same cycle abandons the load, so its accept is dropped
  assign w_we     = (r_state == ST_LOAD) && w_accept && !s_last && !w_full && !load_start;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_LOAD: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
        end else if (w_accept) begin
          if (s_last) begin
            w_state_nxt = w_sum_ok ? ST_DONE : ST_ERROR;
          end else if (w_full) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
        end else if (w_accept && s_last) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (load_start) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    s_ready    = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    unique case (r_state)
      ST_LOAD, ST_DRAIN: begin
        s_ready   = 1'b1;
        load_busy = 1'b1;
      end
      ST_DONE:  load_done  = 1'b1;
      ST_ERROR: load_error = 1'b1;
      default: ;
    endcase
  end

  // --------------------------------------------- counter / checksum / count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_word_count <= '0;
    end else if (load_start) begin
      r_cnt        <= '0;
      r_acc        <= '0;
      r_word_count <= '0;
    end else if ((r_state == ST_LOAD) && w_accept) begin
      r_acc <= w_sum;
      if (s_last) begin
        r_word_count <= r_cnt;
      end else if (w_full) begin
        // Overflow: the word is discarded and the count pins at full depth
        r_word_count <= c_depth;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- read path
  // r_rd_en is captured on the same edge as the RAM read register, so the
  // gate and the data line up with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en <= 1'b0;
    end else begin
      r_rd_en <= (r_state == ST_DONE);
    end
  end

  sys_id_rom_ram #(
    .WIDTH     (ROM_WIDTH),
    .ADDR_BITS (ROM_ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_cnt[ROM_ADDR_BITS-1:0]),
    .wdata (s_data),
    .raddr (rom_addr),
    .rdata (w_ram_q)
  );

  assign rom_data   = r_rd_en ? w_ram_q : '0;
  assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_sys_id_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sys_id_rom_loader
// Description : Self-checking bench for sys_id_rom_loader.
//               Directed and randomized image loads; expectations come from
//               a word-list model of the image (sum, length, stored words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_id_rom_loader;

  localparam int AW    = 6;
  localparam int DEPTH = 64;

  typedef logic [31:0] word_q_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] rom_addr = '0;
  logic [31:0]   rom_data;
  logic          load_busy;
  logic          load_done;
  logic          load_error;
  logic [AW:0]   word_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_done, m_err, m_wc_valid;
  int          m_wc;

  always #5 clk = ~clk;

  sys_id_rom_loader #(.ROM_WIDTH(32), .ROM_ADDR_BITS(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sum_of(input word_q_t d);
    logic [31:0] s = 32'd0;
    foreach (d[i]) s += d[i];
    return s;
  endfunction

  task automatic model_clear();
    m_done = 1'b0; m_err = 1'b0; m_wc = 0; m_wc_valid = 1'b1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_clear();
  endtask

  // Offer one word until accepted (bounded); inputs change only at negedge.
  task automatic send(input logic [31:0] w, input bit last, input bit gap, output bit ok);
    int cyc = 0;
    ok = 1'b0;
    s_data = w;
    s_last = last;
    while (!ok && cyc < 50) begin
      s_valid = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      ok = s_valid && s_ready;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_data(input word_q_t d, input bit gap, inout int stored, inout bit all_ok);
    bit ok;
    foreach (d[i]) begin
      send(d[i], 1'b0, gap, ok);
      all_ok &= ok;
      if (ok && stored < DEPTH) begin
        m_mem[stored]   = d[i];
        m_known[stored] = 1'b1;
      end
      if (ok) stored++;
    end
  endtask

  task automatic check_status();
    check("load_done",  load_done,  m_done);
    check("load_error", load_error, m_err);
    check("load_busy",  load_busy,  1'b0);
    check("s_ready",    s_ready,    1'b0);
    if (m_wc_valid) check("word_count", word_count, m_wc);
  endtask

  task automatic send_check(input logic [31:0] cks, input logic [31:0] sum, input int stored,
                            input bit gap, input bit all_ok);
    bit ok;
    send(cks, 1'b1, gap, ok);
    check("stream_accepts", all_ok & ok, 1'b1);
    m_wc_valid = 1'b1;
    if (stored > DEPTH) begin
      m_done = 1'b0; m_err = 1'b1; m_wc = DEPTH;
    end else if (sum + cks == 32'd0) begin
      m_done = 1'b1; m_err = 1'b0; m_wc = stored;
    end else begin
      m_done = 1'b0; m_err = 1'b1; m_wc_valid = 1'b0;
    end
    check_status();
  endtask

  task automatic read_check(input int addr);
    rom_addr = AW'(addr);
    @(negedge clk);
    check("rom_data", rom_data, m_done ? m_mem[addr] : 32'd0);
  endtask

  task automatic full_load(input word_q_t d, input bit good, input bit gap);
    int stored = 0;
    bit all_ok = 1'b1;
    logic [31:0] cks;
    cks = 32'd0 - sum_of(d) + (good ? 32'd0 : 32'd1);
    pulse_start();
    send_data(d, gap, stored, all_ok);
    send_check(cks, sum_of(d), stored, gap, all_ok);
  endtask

  initial begin
    word_q_t     d;
    int          stored;
    bit          all_ok;
    int          n;

    // ---------------- reset values
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_busy",    load_busy, 1'b0);
    check("rst_done",    load_done, 1'b0);
    check("rst_error",   load_error, 1'b0);
    check("rst_wc",      word_count, 0);
    check("rst_rom",     rom_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    check_status();

    // ---------------- reference image, good then bad checksum
    d = '{32'h5359_4944, 32'h0001_0000, 32'h1234_5678};
    full_load(d, 1'b1, 1'b0);
    read_check(1);
    read_check(0);
    read_check(2);
    full_load(d, 1'b0, 1'b0);
    for (int a = 0; a < DEPTH; a += 7) read_check(a);

    // ---------------- overflow: 65 data words then last
    d.delete();
    for (int i = 0; i < 65; i++) d.push_back($urandom());
    pulse_start();
    stored = 0; all_ok = 1'b1;
    send_data(d, 1'b0, stored, all_ok);
    check("ovf_wc_before_last", word_count, DEPTH);
    check("ovf_busy",           load_busy, 1'b1);
    check("ovf_ready",          s_ready, 1'b1);
    send_check($urandom(), sum_of(d), stored, 1'b0, all_ok);

    // ---------------- empty image; stale reads expose the overflow contents
    d.delete();
    full_load(d, 1'b1, 1'b0);
    read_check(0);
    read_check(63);

    // ---------------- restart mid-load
    d = '{$urandom(), $urandom()};
    pulse_start();
    stored = 0; all_ok = 1'b1;
    send_data(d, 1'b0, stored, all_ok);
    check("restart_part_accepts", all_ok, 1'b1);
    load_start = 1'b1; s_valid = 1'b1; s_data = $urandom(); s_last = 1'b0;
    @(negedge clk);
    load_start = 1'b0; s_valid = 1'b0;
    model_clear();
    check("restart_busy", load_busy, 1'b1);
    d = '{32'hA5A5_A5A5};
    stored = 0; all_ok = 1'b1;
    send_data(d, 1'b0, stored, all_ok);
    send_check(32'h5A5A_5A5B, sum_of(d), stored, 1'b0, all_ok);
    read_check(0);
    read_check(1);

    // ---------------- reset mid-load with s_valid held
    d = '{$urandom(), $urandom(), $urandom()};
    pulse_start();
    stored = 0; all_ok = 1'b1;
    send_data(d, 1'b0, stored, all_ok);
    s_valid = 1'b1; s_data = $urandom(); s_last = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", s_ready, 1'b0);
    check("rstmid_busy",  load_busy, 1'b0);
    rom_addr = '0;
    @(negedge clk);
    check("rstmid_ready2", s_ready, 1'b0);
    check("rstmid_rom",    rom_data, 32'd0);
    s_valid = 1'b0;
    model_clear();
    check_status();

    // ---------------- good load, then reload with backpressure
    d.delete();
    for (int i = 0; i < 5; i++) d.push_back($urandom());
    full_load(d, 1'b1, 1'b0);
    read_check(2);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    model_clear();
    check("reload_done_drop", load_done, 1'b0);
    @(negedge clk);
    check("reload_rom_zero", rom_data, 32'd0);
    d.delete();
    for (int i = 0; i < 6; i++) d.push_back($urandom());
    stored = 0; all_ok = 1'b1;
    send_data(d, 1'b1, stored, all_ok);
    check("reload_mid_rom_zero", rom_data, 32'd0);
    send_check(32'd0 - sum_of(d), sum_of(d), stored, 1'b1, all_ok);
    read_check(0);
    read_check(5);

    // ---------------- randomized loads
    for (int it = 0; it < 8; it++) begin
      d.delete();
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) d.push_back($urandom());
      full_load(d, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      if (m_done && n > 0) begin
        for (int k = 0; k < 3; k++) read_check($urandom_range(0, n - 1));
      end else begin
        read_check($urandom_range(0, DEPTH - 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
